// File: rtl/act_pkg.sv
// Shared activation definitions: mode encodings and the default accumulator-aligned lane width.
package act_pkg;

   localparam int unsigned ACT_DATA_W = 33;

   localparam logic [1:0] ACT_BYPASS = 2'b00;
   localparam logic [1:0] ACT_RELU   = 2'b01;
   localparam logic [1:0] ACT_LEAKY  = 2'b10;
   localparam logic [1:0] ACT_CLAMP  = 2'b11;

endpackage

// File: rtl/act_lane.sv
// One lane of the activation function, purely combinational.
module act_lane
   import act_pkg::*;
#(
   parameter int unsigned DATA_W     = ACT_DATA_W,
   parameter int unsigned LEAK_SHIFT = 3
) (
   input  logic [DATA_W-1:0] x,
   input  logic [1:0]        mode,
   input  logic [DATA_W-1:0] clamp_max,
   output logic [DATA_W-1:0] y
);

   logic signed [DATA_W-1:0] xs;
   logic signed [DATA_W-1:0] cs;

   assign xs = x;
   assign cs = clamp_max;

   always_comb begin
      y = x;
      unique case (mode)
         ACT_BYPASS: y = x;
         ACT_RELU:   y = x[DATA_W-1] ? '0 : x;
         ACT_LEAKY:  y = x[DATA_W-1] ? DATA_W'(xs >>> LEAK_SHIFT) : x;
         ACT_CLAMP: begin
            // A negative ceiling would otherwise leak a negative value through.
            if (x[DATA_W-1] || clamp_max[DATA_W-1]) y = '0;
            else if (xs > cs)                      y = clamp_max;
            else                                   y = x;
         end
         default:    y = x;
      endcase
   end

endmodule

// File: rtl/relu_pipe.sv
// Multi-lane activation unit: two registered stages with valid/ready backpressure and a
// saturating counter of negative lanes seen on accepted beats.
module relu_pipe
   import act_pkg::*;
#(
   parameter int unsigned DATA_W     = ACT_DATA_W,
   parameter int unsigned LANES      = 4,
   parameter int unsigned LEAK_SHIFT = 3,
   parameter int unsigned CNT_W      = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [1:0]              mode,
   input  logic [DATA_W-1:0]       clamp_max,
   input  logic                    s_valid,
   output logic                    s_ready,
   input  logic [LANES*DATA_W-1:0] s_data,
   output logic                    m_valid,
   input  logic                    m_ready,
   output logic [LANES*DATA_W-1:0] m_data,
   output logic [CNT_W-1:0]        neg_cnt,
   input  logic                    stat_clr
);

   localparam int unsigned POP_W = $clog2(LANES + 1);

   logic                    s1_valid_q;
   logic [LANES*DATA_W-1:0] s1_data_q;
   logic [1:0]              s1_mode_q;
   logic [DATA_W-1:0]       s1_clamp_q;
   logic                    s2_valid_q;
   logic [LANES*DATA_W-1:0] s2_data_q;
   logic [LANES*DATA_W-1:0] act_y;
   logic [CNT_W-1:0]        cnt_q;
   logic [CNT_W-1:0]        cnt_d;
   logic [CNT_W-1:0]        cnt_base;
   logic [CNT_W:0]          cnt_sum;
   logic [POP_W-1:0]        neg_lanes;
   logic                    advance;
   logic                    accept;

   assign advance = !s2_valid_q || m_ready;
   assign s_ready = !s1_valid_q || advance;
   assign accept  = s_valid && s_ready;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      act_lane #(
         .DATA_W     (DATA_W),
         .LEAK_SHIFT (LEAK_SHIFT)
      ) u_act_lane (
         .x         (s1_data_q[i*DATA_W +: DATA_W]),
         .mode      (s1_mode_q),
         .clamp_max (s1_clamp_q),
         .y         (act_y[i*DATA_W +: DATA_W])
      );
   end

   always_comb begin
      neg_lanes = '0;
      for (int i = 0; i < LANES; i++) begin
         neg_lanes = neg_lanes + POP_W'(s_data[i*DATA_W + DATA_W - 1]);
      end
   end

   // Clear takes priority over the old value but not over the beat arriving in the same cycle.
   always_comb begin
      cnt_base = stat_clr ? '0 : cnt_q;
      cnt_sum  = {1'b0, cnt_base} + (CNT_W + 1)'(neg_lanes);
      cnt_d    = cnt_base;
      if (accept) cnt_d = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_data_q  <= '0;
         s1_mode_q  <= ACT_BYPASS;
         s1_clamp_q <= '0;
         s2_valid_q <= 1'b0;
         s2_data_q  <= '0;
         cnt_q      <= '0;
      end else begin
         cnt_q <= cnt_d;
         if (s_ready) begin
            s1_valid_q <= s_valid;
            if (s_valid) begin
               s1_data_q  <= s_data;
               s1_mode_q  <= mode;
               s1_clamp_q <= clamp_max;
            end
         end
         if (advance) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) s2_data_q <= act_y;
         end
      end
   end

   assign m_valid = s2_valid_q;
   assign m_data  = s2_data_q;
   assign neg_cnt = cnt_q;

endmodule

// File: doc/relu_pipe.md
# relu_pipe

Streaming, multi-lane activation unit for the accelerator datapath. It accepts LANES packed signed fixed-point words per beat on a valid/ready interface and applies a run-time-selected activation (bypass, ReLU, leaky ReLU, clamped ReLU) per lane. Results leave through a 2-stage registered pipeline with full backpressure. It sits between the MAC/accumulator output and the result writeback buffer, and keeps a saturating count of negative inputs for debug.

## Interface
- DATA_W, 33: lane width in bits, two's complement, MSB is sign.
- LANES, 4: lanes per beat.
- LEAK_SHIFT, 3: leaky slope as an arithmetic right shift (slope 2^-LEAK_SHIFT). Range 1..DATA_W-1.
- CNT_W, 16: width of the negative-input counter.

- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- mode  in  2  activation: 00 bypass, 01 relu, 10 leaky, 11 clamp. Sampled per accepted beat.
- clamp_max  in  DATA_W  clamp ceiling, treated as signed. Sampled per accepted beat.
- s_valid  in  1  input beat valid.
- s_ready  out  1  unit can accept a beat.
- s_data  in  LANES*DATA_W  lane i is bits [i*DATA_W +: DATA_W].
- m_valid  out  1  output beat valid.
- m_ready  in  1  downstream accepts.
- m_data  out  LANES*DATA_W  activated lanes, same packing as s_data.
- neg_cnt  out  CNT_W  saturating count of negative lanes accepted.
- stat_clr  in  1  clears neg_cnt.

## Operation
- Per lane x (signed DATA_W):
  - bypass: y = x.
  - relu: y = x if x[DATA_W-1]==0, else 0.
  - leaky: y = x if x ≥ 0, else x >>> LEAK_SHIFT (arithmetic shift). The result rounds toward −inf, so -1 maps to -1.
  - clamp: y = 0 if x < 0; y = clamp_max if x > clamp_max; else x. If clamp_max is negative, every lane outputs 0.
- Output width equals input width, so no overflow is possible in any mode.
- Stage 1 (S1) registers the sampled x, mode and clamp_max together with a valid bit. Stage 2 (S2) registers y and drives m_valid/m_data.
- Advance rule: the pipeline moves when S2 is empty or m_ready=1.
  - When the pipeline moves, S1→S2, and input→S1 if s_valid.
  - When it does not move, both stages hold, and m_data stays stable while m_valid=1.
- s_ready = !S1.valid || advance. This is a combinational path from m_ready.
- neg_cnt adds the number of lanes with a set sign bit in each accepted beat (s_valid && s_ready), in all modes. It saturates at 2^CNT_W−1.
  - If stat_clr and an accepted beat occur in the same cycle, the result is neg_cnt = that beat's count.
- Beats are never dropped, duplicated or reordered.

## Timing
- Latency: 2 cycles from acceptance to m_valid, when there is no backpressure.
- Throughput: 1 beat per cycle while m_ready=1.
- Reset values: S1.valid=0, S2.valid=0, m_valid=0, m_data=0, neg_cnt=0. s_ready=1 in the first cycle after reset.
- rst asserted mid-stream discards both stages in flight on that edge and does not count the beat presented that cycle.
- m_ready=0 while S2 is full and S1 is full forces s_ready=0. Capacity is 2 beats.
- The pipeline refills back-to-back with no bubble when m_ready returns to 1.
- Changing mode or clamp_max affects only beats accepted after the change.

## Structure
- A shared package act_pkg holds:
  - mode encodings as localparams: ACT_BYPASS=2'b00, ACT_RELU=2'b01, ACT_LEAKY=2'b10, ACT_CLAMP=2'b11.
  - a default DATA_W of 33, so accumulator width stays consistent across the datapath.
- One sub-module, act_lane: purely combinational (x, mode, clamp_max) → y. It is generated LANES times between S1 and S2.
- relu_pipe contains the handshake, stage registers and counter only.

## Test plan
- Reset then idle:
  - Expect m_valid=0, m_data=0, neg_cnt=0, s_ready=1.
  - Assert rst mid-stream with 2 beats in flight: neither beat appears afterwards.
- Mode sweep, LANES=4, lanes {5, −8, 0, −1} with m_ready=1, each result arriving 2 cycles after its input:
  - relu → {5, 0, 0, 0}.
  - leaky (shift 3) → {5, −1, 0, −1}.
  - bypass → unchanged.
  - clamp with clamp_max=4 → {4, 0, 0, 0}.
- Clamp edges: clamp_max=−3 gives all zeros. Inputs 2^32−1 and −2^32 with clamp_max=100 give {100, 0}.
- Backpressure:
  - Stream 10 beats with m_ready toggling in a 1,0,0,1 pattern.
  - Expect s_ready to drop once 2 beats are held, m_data to stay stable while stalled, and all 10 beats out in order.
  - Once m_ready is held at 1, expect 1 beat/cycle.
- Counter:
  - Feed 3 beats of all-negative lanes: neg_cnt=12.
  - Pulse stat_clr together with a beat holding 1 negative lane: neg_cnt=1.
  - With CNT_W=4, feed 5 all-negative beats: saturates at 15.
- Mode change: switch relu→bypass between consecutive accepted beats. The first beat is relu'd and the second passes unchanged, despite the overlap in the pipeline.
